// File: rtl/vec_pkg.sv
// Shared opcodes, command word layout and FSM state encoding
// for the display-list player.
package vec_pkg;

    localparam logic [1:0] OP_JUMP = 2'b00;
    localparam logic [1:0] OP_DRAW = 2'b01;
    localparam logic [1:0] OP_END  = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    localparam int OP_W  = 2;
    localparam int Y_LSB = 0;

    function automatic int x_lsb(input int coord_w);
        return coord_w;
    endfunction

    function automatic int op_lsb(input int coord_w);
        return 2 * coord_w;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_DATA,
        ST_WAIT_READY,
        ST_SETTLE,
        ST_FINISH
    } vlp_state_t;

endpackage

// File: rtl/vlp_settle_timer.sv
// Count-down timer holding off the sequencer after each pulse
// while the controller's ready output catches up.
module vlp_settle_timer #(
    parameter int CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic tick,
    output logic done
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] cnt;

    // load arms the window so done rises on the CYCLES-th tick
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(CYCLES - 1);
        end else if (tick && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/vector_list_player.sv
// Display-list sequencer: fetches command words and emits
// jump/draw pulses to the vector beam controller.
module vector_list_player
    import vec_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int COORD_W = 12,
    parameter int SETTLE  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   frame_start,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_rd,
    input  logic [2+2*COORD_W-1:0] mem_data,
    output logic [COORD_W-1:0]     x,
    output logic [COORD_W-1:0]     y,
    output logic                   jump,
    output logic                   draw,
    input  logic                   ready,
    output logic                   busy,
    output logic                   frame_done,
    output logic [7:0]             overrun_cnt
);

    vlp_state_t state, state_d;

    logic [ADDR_W-1:0]  addr_q;
    logic [COORD_W-1:0] x_q, y_q;
    logic [1:0]         op_q;
    logic               pending_q;
    logic [7:0]         ovr_q;

    logic [1:0]         cmd_op;
    logic [COORD_W-1:0] cmd_x, cmd_y;

    logic addr_max;
    logic addr_inc, addr_clr;
    logic latch_cmd, fire;
    logic timer_load, timer_tick, settle_done;

    assign cmd_op = mem_data[op_lsb(COORD_W) +: OP_W];
    assign cmd_x  = mem_data[x_lsb(COORD_W) +: COORD_W];
    assign cmd_y  = mem_data[Y_LSB +: COORD_W];

    assign addr_max = &addr_q;

    vlp_settle_timer #(
        .CYCLES (SETTLE)
    ) u_settle (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .tick  (timer_tick),
        .done  (settle_done)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_d;
    end

    // next-state and per-state strobes
    always_comb begin
        state_d    = state;
        addr_inc   = 1'b0;
        addr_clr   = 1'b0;
        latch_cmd  = 1'b0;
        fire       = 1'b0;
        timer_load = 1'b0;
        timer_tick = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (frame_start && enable) begin
                    addr_clr = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                unique case (cmd_op)
                    OP_NOP: begin
                        if (addr_max) begin
                            state_d = ST_FINISH;
                        end else begin
                            addr_inc = 1'b1;
                            state_d  = ST_FETCH;
                        end
                    end
                    OP_END: state_d = ST_FINISH;
                    default: begin
                        latch_cmd = 1'b1;
                        state_d   = ST_WAIT_READY;
                    end
                endcase
            end
            ST_WAIT_READY: begin
                if (ready) begin
                    fire       = 1'b1;
                    timer_load = 1'b1;
                    state_d    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                timer_tick = 1'b1;
                if (settle_done) begin
                    if (!enable || addr_max) begin
                        state_d = ST_FINISH;
                    end else begin
                        addr_inc = 1'b1;
                        state_d  = ST_FETCH;
                    end
                end
            end
            ST_FINISH: begin
                if ((pending_q || frame_start) && enable) begin
                    addr_clr = 1'b1;
                    state_d  = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // list address counter; wraps only via FINISH
    always_ff @(posedge clk) begin
        if (reset)         addr_q <= '0;
        else if (addr_clr) addr_q <= '0;
        else if (addr_inc) addr_q <= addr_q + 1'b1;
    end

    // command latch; x/y hold until the next JUMP/DRAW
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q  <= '0;
            y_q  <= '0;
            op_q <= OP_JUMP;
        end else if (latch_cmd) begin
            x_q  <= cmd_x;
            y_q  <= cmd_y;
            op_q <= cmd_op;
        end
    end

    // one-deep pending start and saturating overrun count
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= 1'b0;
            ovr_q     <= '0;
        end else if (state == ST_FINISH) begin
            pending_q <= 1'b0;
        end else if (frame_start && state != ST_IDLE) begin
            pending_q <= 1'b1;
            if (ovr_q != 8'hFF) ovr_q <= ovr_q + 1'b1;
        end
    end

    assign mem_addr    = addr_q;
    assign mem_rd      = (state == ST_FETCH);
    assign x           = x_q;
    assign y           = y_q;
    assign jump        = fire && (op_q == OP_JUMP);
    assign draw        = fire && (op_q == OP_DRAW);
    assign busy        = (state != ST_IDLE);
    assign frame_done  = (state == ST_FINISH);
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_vector_list_player.sv
// Directed bench for vector_list_player with a synchronous
// RAM model and a negedge pulse monitor.
module tb_vector_list_player;
    import vec_pkg::*;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        frame_start;
    logic [9:0]  mem_addr;
    logic        mem_rd;
    logic [25:0] mem_data;
    logic [11:0] x, y;
    logic        jump, draw;
    logic        ready;
    logic        busy;
    logic        frame_done;
    logic [7:0]  overrun_cnt;

    logic [25:0] ram [0:1023];

    int tests, fails, cyc;
    int jump_cnt, draw_cnt, done_cnt, both_cnt, nr_cnt;
    int jcyc, dcyc;
    logic [11:0] jx, jy, dx, dy;
    int addr_log [$];

    vector_list_player dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .frame_start (frame_start),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .x           (x),
        .y           (y),
        .jump        (jump),
        .draw        (draw),
        .ready       (ready),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun_cnt (overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous display-list RAM
    always @(posedge clk) begin
        if (mem_rd) mem_data <= ram[mem_addr];
    end

    // pulse monitor
    always @(negedge clk) begin
        cyc++;
        if (jump) begin
            jump_cnt++; jx = x; jy = y; jcyc = cyc;
        end
        if (draw) begin
            draw_cnt++; dx = x; dy = y; dcyc = cyc;
        end
        if (jump && draw) both_cnt++;
        if ((jump || draw) && !ready) nr_cnt++;
        if (frame_done) done_cnt++;
        if (mem_rd) addr_log.push_back(int'(mem_addr));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        jump_cnt = 0; draw_cnt = 0; done_cnt = 0;
        both_cnt = 0; nr_cnt = 0;
        jx = 0; jy = 0; dx = 0; dy = 0; jcyc = 0; dcyc = 0;
        addr_log.delete();
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start();
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (k < budget) begin
            @(negedge clk);
            if (frame_done) break;
            k++;
        end
        if (k >= budget) chk({tag, "_timeout"}, 0, 1);
        step(1);
    endtask

    function automatic logic [25:0] cmd(input logic [1:0] op,
                                        input int cx, input int cy);
        return {op, 12'(cx), 12'(cy)};
    endfunction

    task automatic load_basic();
        for (int i = 0; i < 1024; i++) ram[i] = cmd(OP_END, 0, 0);
        ram[0] = cmd(OP_JUMP, 100, 200);
        ram[1] = cmd(OP_DRAW, 300, 400);
        ram[2] = cmd(OP_END, 0, 0);
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        clr();
        reset = 1'b1; enable = 1'b0; frame_start = 1'b0; ready = 1'b0;
        mem_data = '0;
        load_basic();
        step(3);
        reset = 1'b0;
        step(1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pulses", int'({jump, draw, frame_done, mem_rd}), 0);
        chk("rst_xy", int'({x, y}), 0);
        chk("rst_ovr", int'(overrun_cnt), 0);

        // 1: basic list, ready tied high
        clr(); enable = 1'b1; ready = 1'b1;
        start();
        wait_done("t1", 100);
        chk("t1_jump_cnt", jump_cnt, 1);
        chk("t1_jump_xy", int'({jx, jy}), int'({12'd100, 12'd200}));
        chk("t1_draw_cnt", draw_cnt, 1);
        chk("t1_draw_xy", int'({dx, dy}), int'({12'd300, 12'd400}));
        chk("t1_gap", int'(dcyc - jcyc >= 5), 1);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_busy_after", int'(busy), 0);
        chk("t1_both", both_cnt, 0);

        // 2: ready held low after the first fetch
        clr(); ready = 1'b0;
        start();
        step(50);
        chk("t2_no_pulse", jump_cnt + draw_cnt, 0);
        chk("t2_x_held", int'(x), 100);
        chk("t2_y_held", int'(y), 200);
        ready = 1'b1;
        @(negedge clk);
        chk("t2_jump_on_ready", int'(jump), 1);
        wait_done("t2", 100);
        chk("t2_draw_cnt", draw_cnt, 1);
        chk("t2_not_ready", nr_cnt, 0);
        chk("t2_done_cnt", done_cnt, 1);

        // 3: NOPs ahead of a corner draw
        for (int i = 0; i < 4; i++) ram[i] = cmd(OP_NOP, 7, 7);
        ram[2] = cmd(OP_DRAW, 4095, 0);
        ram[3] = cmd(OP_END, 0, 0);
        clr();
        start();
        wait_done("t3", 100);
        chk("t3_draw_cnt", draw_cnt, 1);
        chk("t3_jump_cnt", jump_cnt, 0);
        chk("t3_draw_xy", int'({dx, dy}), int'({12'd4095, 12'd0}));
        chk("t3_rd_count", addr_log.size(), 4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            chk($sformatf("t3_addr%0d", i), addr_log[i], i);

        // 4: overrun during a busy frame
        load_basic();
        clr();
        start();
        for (int i = 0; i < 3; i++) begin
            step(1);
            start();
        end
        chk("t4_ovr", int'(overrun_cnt), 3);
        wait_done("t4a", 100);
        chk("t4_restart_busy", int'(busy), 1);
        chk("t4_restart_rd", int'(mem_rd), 1);
        chk("t4_restart_addr", int'(mem_addr), 0);
        wait_done("t4b", 100);
        chk("t4_done_cnt", done_cnt, 2);
        chk("t4_draw_cnt", draw_cnt, 2);
        chk("t4_busy_after", int'(busy), 0);
        chk("t4_ovr_final", int'(overrun_cnt), 3);

        // 5: full list of draws wraps to an implicit END
        for (int i = 0; i < 1024; i++)
            ram[i] = cmd(OP_DRAW, i, i ^ 'hABC);
        clr();
        start();
        wait_done("t5", 1024 * 6 + 50);
        chk("t5_draw_cnt", draw_cnt, 1024);
        chk("t5_last_xy", int'({dx, dy}), int'({12'd1023, 12'h943}));
        chk("t5_done_cnt", done_cnt, 1);
        chk("t5_busy_after", int'(busy), 0);
        clr(); ready = 1'b0;
        start();
        step(6);
        chk("t5_next_rd_count", addr_log.size(), 1);
        if (addr_log.size() > 0)
            chk("t5_next_addr", addr_log[0], 0);

        // 6: reset while parked in WAIT_READY
        chk("t6_parked_busy", int'(busy), 1);
        reset = 1'b1;
        step(1);
        clr();
        reset = 1'b0;
        chk("t6_busy", int'(busy), 0);
        chk("t6_outs", int'({jump, draw, frame_done, mem_rd}), 0);
        chk("t6_xy", int'({x, y}), 0);
        chk("t6_ovr", int'(overrun_cnt), 0);
        enable = 1'b0; ready = 1'b1;
        start();
        step(20);
        chk("t6_pulses", jump_cnt + draw_cnt + done_cnt, 0);
        chk("t6_no_rd", addr_log.size(), 0);
        chk("t6_idle", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
